uart_rx_fifo: RTL and testbench

//  Byte buffer directly downstream of the UART receiver. It captures each completed byte
//  (rx_data/rx_status) into a DEPTH-entry FIFO and presents bytes to the CPU peripheral

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_fifo_ram.sv | 30 +++
 rtl/uart_rx_fifo.sv | 98 +++++++++
 tb/tb_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and the read-FSM state type
package uart_pkg;
  localparam int UART_DATA_W       = 8;
  localparam int UART_RXFIFO_DEPTH = 8;

  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// rtl/uart_fifo_ram.sv - DEPTH x 8 receive storage, one write port and a registered read port
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RXFIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   sampleclk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [UART_DATA_W-1:0] rd_data
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge sampleclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds the last popped byte until the next pop.
  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with read handshake, occupancy, overrun and irq
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_RXFIFO_DEPTH,
  parameter int CNT_W     = $clog2(DEPTH) + 1,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                   sampleclk,
  input  logic                   reset,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_status,
  input  logic                   rd_req,
  input  logic                   ovr_clr,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [CNT_W-1:0]       count,
  output logic                   overrun,
  output logic                   irq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rx_status_d;
  rd_state_t        state;
  logic             push;
  logic             pop;
  logic             push_ok;
  logic             drop;

  // rx_status_d resets high so a level already present at reset release is not a byte.
  assign push    = rx_status & ~rx_status_d;
  assign pop     = (state == RD_IDLE) & rd_req & ~empty;
  assign push_ok = push & (~full | pop);
  assign drop    = push & ~push_ok;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign irq   = (count >= CNT_W'(IRQ_LEVEL));

  uart_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .sampleclk (sampleclk),
    .reset     (reset),
    .wr_en     (push_ok),
    .wr_addr   (wr_ptr),
    .wr_data   (rx_data),
    .rd_en     (pop),
    .rd_addr   (rd_ptr),
    .rd_data   (rd_data)
  );

  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      rx_status_d <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun     <= 1'b0;
    end else begin
      rx_status_d <= rx_status;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      state    <= RD_IDLE;
      rd_valid <= 1'b0;
    end else begin
      case (state)
        RD_IDLE: begin
          rd_valid <= pop;
          if (pop) state <= RD_RESP;
        end
        RD_RESP: begin
          rd_valid <= 1'b0;
          state    <= RD_IDLE;
        end
        default: begin
          rd_valid <= 1'b0;
          state    <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench with a queue model for uart_rx_fifo
module tb_uart_rx_fifo;
  localparam int DEPTH     = 8;
  localparam int CNT_W     = 4;
  localparam int IRQ_LEVEL = 4;

  logic             sampleclk;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_status;
  logic             rd_req;
  logic             ovr_clr;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overrun;
  logic             irq;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W), .IRQ_LEVEL(IRQ_LEVEL)) dut (
    .sampleclk (sampleclk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rd_req    (rd_req),
    .ovr_clr   (ovr_clr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overrun   (overrun),
    .irq       (irq)
  );

  initial sampleclk = 1'b0;
  always #5 sampleclk = ~sampleclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus the spec's one-strobe-then-rest read rule.
  logic [7:0] m_q[$];
  logic       m_prev;
  logic       m_ovr;
  logic       m_valid;
  logic [7:0] m_data;
  bit         m_push;
  bit         m_pop;
  int         m_sz;

  always @(posedge sampleclk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_prev  = 1'b1;
      m_ovr   = 1'b0;
      m_valid = 1'b0;
      m_data  = 8'h00;
    end else begin
      m_sz   = m_q.size();
      m_push = rx_status && !m_prev;
      m_prev = rx_status;
      m_pop  = rd_req && !m_valid && (m_sz > 0);
      if (m_pop) m_data = m_q.pop_front();
      if (m_push && (m_sz < DEPTH || m_pop)) m_q.push_back(rx_data);
      if (m_push && m_sz == DEPTH && !m_pop) m_ovr = 1'b1;
      else if (ovr_clr)                      m_ovr = 1'b0;
      m_valid = m_pop;
    end
  end

  logic prev_valid = 1'b0;
  always @(posedge sampleclk) begin
    #1;
    check("cyc_rd_valid", rd_valid, m_valid);
    check("cyc_rd_data",  rd_data,  m_data);
    check("cyc_count",    count,    m_q.size());
    check("cyc_empty",    empty,    m_q.size() == 0);
    check("cyc_full",     full,     m_q.size() == DEPTH);
    check("cyc_irq",      irq,      m_q.size() >= IRQ_LEVEL);
    check("cyc_overrun",  overrun,  m_ovr);
    if (rd_valid) check("cyc_back_to_back", prev_valid, 1'b0);
    prev_valid = rd_valid;
  end

  task automatic send_byte(input logic [7:0] b, input int hi);
    rx_data   = b;
    rx_status = 1'b1;
    repeat (hi) @(negedge sampleclk);
    rx_status = 1'b0;
    @(negedge sampleclk);
  endtask

  task automatic read1(input logic [7:0] exp);
    rd_req = 1'b1;
    @(negedge sampleclk);
    check("read_strobe", rd_valid, 1'b1);
    check("read_data", rd_data, exp);
    rd_req = 1'b0;
    @(negedge sampleclk);
    check("read_strobe_off", rd_valid, 1'b0);
  endtask

  logic [7:0] got[$];

  initial begin
    reset = 1'b0; rx_data = 8'h00; rx_status = 1'b1; rd_req = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(negedge sampleclk);
    reset = 1'b1;
    repeat (3) @(negedge sampleclk);
    check("t1_count", count, 0);
    check("t1_empty", empty, 1'b1);
    check("t1_rd_valid", rd_valid, 1'b0);
    rx_status = 1'b0;
    @(negedge sampleclk);
    check("t1_count_after", count, 0);

    send_byte(8'h55, 5);
    send_byte(8'hA3, 5);
    check("t2_count", count, 2);
    read1(8'h55);
    read1(8'hA3);
    check("t2_empty", empty, 1'b1);

    for (int i = 0; i < 9; i++) send_byte(8'(i), 1);
    check("t3_full", full, 1'b1);
    check("t3_overrun", overrun, 1'b1);
    check("t3_count", count, 8);
    for (int i = 0; i < 8; i++) read1(8'(i));
    ovr_clr = 1'b1;
    @(negedge sampleclk);
    ovr_clr = 1'b0;
    check("t3_ovr_clr", overrun, 1'b0);
    check("t3_empty", empty, 1'b1);

    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1);
    check("t4_full", full, 1'b1);
    rd_req = 1'b1; rx_data = 8'h7E; rx_status = 1'b1;
    @(negedge sampleclk);
    check("t4_pop_data", rd_data, 8'h10);
    check("t4_count", count, 8);
    check("t4_overrun", overrun, 1'b0);
    rd_req = 1'b0; rx_status = 1'b0;
    @(negedge sampleclk);
    for (int i = 1; i < 8; i++) read1(8'h10 + 8'(i));
    read1(8'h7E);
    check("t4_empty", empty, 1'b1);

    rd_req = 1'b1;
    @(negedge sampleclk);
    check("t5_empty_read", rd_valid, 1'b0);
    rd_req = 1'b0;
    send_byte(8'hA1, 1);
    send_byte(8'hA2, 1);
    send_byte(8'hA3, 1);
    rd_req = 1'b1;
    got.delete();
    repeat (8) begin
      @(negedge sampleclk);
      if (rd_valid) got.push_back(rd_data);
    end
    rd_req = 1'b0;
    check("t5_strobes", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) check("t5_held_data", got[i], 8'hA1 + 8'(i));
    rx_data = 8'h5A; rx_status = 1'b1; rd_req = 1'b1;
    @(negedge sampleclk);
    check("t5_no_bypass", rd_valid, 1'b0);
    check("t5_bypass_count", count, 1);
    rd_req = 1'b0; rx_status = 1'b0;
    @(negedge sampleclk);
    read1(8'h5A);

    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i), 2);
      check("t6_irq", irq, i == 4);
    end
    read1(8'h01);
    check("t6_irq_after_pop", irq, 1'b0);
    check("t6_count", count, 3);
    rd_req = 1'b1;
    @(negedge sampleclk);
    check("t6_resp", rd_valid, 1'b1);
    rd_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t6_reset_valid", rd_valid, 1'b0);
    check("t6_reset_count", count, 0);
    check("t6_reset_empty", empty, 1'b1);
    @(negedge sampleclk);
    reset = 1'b1;
    repeat (3) @(negedge sampleclk);
    check("t6_post_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
